voice_scheduler: RTL and testbench

Polyphonic voice controller in front of the waveform generators (square/saw/sine stages). It accepts MIDI note-on/note-off events and allocates them to `NUM_VOICES` voice slots, stealing a voice when all are busy. Each slot holds its own phase accumulator. On every sample tick it sweeps all slots, one per clock, and presents `phase`/`midi`/`valid` to the shared waveform stage. This time-multiplexes one generator across all voices.

---
 rtl/synth_pkg.sv | 30 +++
 rtl/phase_inc_rom.sv | 38 +++
 rtl/voice_scheduler.sv | 167 ++++++++++++++++
 tb/tb_voice_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path.
package synth_pkg;

    localparam int MIDI_W      = 7;
    localparam int PHASE_W     = 24;
    localparam int SAMPLE_RATE = 48000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    typedef struct packed {
        logic               active;
        logic [MIDI_W-1:0]  midi;
        logic [PHASE_W-1:0] inc;
        logic [PHASE_W-1:0] phase;
    } voice_t;

    // Equal-tempered phase increment for a MIDI note (A4 = note 69 = 440 Hz).
    // Only ever evaluated at elaboration to build the constant ROM table.
    function automatic logic [PHASE_W-1:0] note_inc(input int n);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0)) * (2.0 ** PHASE_W)
            / real'(SAMPLE_RATE);
        return PHASE_W'($rtoi(f + 0.5));
    endfunction

endpackage

// File: rtl/phase_inc_rom.sv
// Registered 128-entry note -> phase increment lookup, one cycle latency.
module phase_inc_rom
    import synth_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [MIDI_W-1:0]  i_addr,
    output logic [PHASE_W-1:0] o_data
);

    typedef logic [127:0][PHASE_W-1:0] rom_t;

    function automatic rom_t build_rom();
        rom_t t;
        for (int n = 0; n < 128; n++) begin
            t[n] = note_inc(n);
        end
        return t;
    endfunction

    localparam rom_t ROM_TABLE = build_rom();

    logic [PHASE_W-1:0] data_d, data_q;

    // Table read for the presented address.
    always_comb begin
        data_d = ROM_TABLE[i_addr];
    end

    // Output register gives the one-cycle lookup latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign o_data = data_q;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator with per-slot phase accumulators, swept one
// slot per clock on each sample tick into a shared waveform stage.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_tick,
    input  logic                          i_note_valid,
    input  logic                          i_note_on,
    input  logic [6:0]                    i_midi,
    output logic                          o_note_ready,
    output logic [PHASE_W-1:0]            o_phase,
    output logic [6:0]                    o_midi,
    output logic                          o_valid,
    output logic [$clog2(NUM_VOICES)-1:0] o_voice,
    output logic                          o_last,
    output logic                          o_overrun
);

    localparam int VW = $clog2(NUM_VOICES);

    state_e                    state_q, state_d;
    voice_t [NUM_VOICES-1:0]   voice_q, voice_d;
    logic   [VW-1:0]           idx_q, idx_d;
    logic   [VW-1:0]           steal_q, steal_d;
    logic   [6:0]              note_q, note_d;
    logic   [PHASE_W-1:0]      phase_q, phase_d;
    logic   [6:0]              midi_q, midi_d;
    logic                      valid_q, valid_d;
    logic   [VW-1:0]           voice_out_q, voice_out_d;
    logic                      last_q, last_d;
    logic                      overrun_q, overrun_d;

    logic   [PHASE_W-1:0]      rom_data;
    logic                      free_any;
    logic   [VW-1:0]           free_idx;
    logic   [VW-1:0]           tgt;
    logic                      accept;

    // A tick always wins the cycle, so events are refused while it is high.
    assign o_note_ready = (state_q == ST_IDLE) && !i_tick;
    assign accept       = i_note_valid && o_note_ready;

    phase_inc_rom u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (i_midi),
        .o_data (rom_data)
    );

    // Lowest-index inactive slot; scanning downward leaves the lowest hit.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_q[i].active) begin
                free_any = 1'b1;
                free_idx = VW'(i);
            end
        end
    end

    // Next-state, slot updates and sweep output staging.
    always_comb begin
        state_d     = state_q;
        voice_d     = voice_q;
        idx_d       = idx_q;
        steal_d     = steal_q;
        note_d      = note_q;
        phase_d     = phase_q;
        midi_d      = midi_q;
        voice_out_d = voice_out_q;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        overrun_d   = i_tick && (state_q != ST_IDLE);
        tgt         = free_any ? free_idx : steal_q;

        case (state_q)
            ST_IDLE: begin
                if (i_tick) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end else if (accept) begin
                    if (i_note_on) begin
                        // ROM address is i_midi directly; data lands in ALLOC.
                        note_d  = i_midi;
                        state_d = ST_ALLOC;
                    end else begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (voice_q[i].active && voice_q[i].midi == i_midi)
                                voice_d[i].active = 1'b0;
                        end
                    end
                end
            end

            ST_ALLOC: begin
                // Steal pointer only advances when a live voice is taken.
                if (!free_any) steal_d = steal_q + 1'b1;
                voice_d[tgt].active = 1'b1;
                voice_d[tgt].midi   = note_q;
                voice_d[tgt].inc    = rom_data;
                voice_d[tgt].phase  = '0;
                state_d             = ST_IDLE;
            end

            ST_SWEEP: begin
                phase_d     = voice_q[idx_q].phase;
                midi_d      = voice_q[idx_q].midi;
                valid_d     = voice_q[idx_q].active;
                voice_out_d = idx_q;
                last_d      = (idx_q == VW'(NUM_VOICES - 1));
                if (voice_q[idx_q].active)
                    voice_d[idx_q].phase = voice_q[idx_q].phase + voice_q[idx_q].inc;
                if (idx_q == VW'(NUM_VOICES - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears every slot and output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            voice_q     <= '0;
            idx_q       <= '0;
            steal_q     <= '0;
            note_q      <= '0;
            phase_q     <= '0;
            midi_q      <= '0;
            valid_q     <= 1'b0;
            voice_out_q <= '0;
            last_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            voice_q     <= voice_d;
            idx_q       <= idx_d;
            steal_q     <= steal_d;
            note_q      <= note_d;
            phase_q     <= phase_d;
            midi_q      <= midi_d;
            valid_q     <= valid_d;
            voice_out_q <= voice_out_d;
            last_q      <= last_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_phase   = phase_q;
    assign o_midi    = midi_q;
    assign o_valid   = valid_q;
    assign o_voice   = voice_out_q;
    assign o_last    = last_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: event-level voice model plus
// directed scenarios and a randomized note/tick mix.
module tb_voice_scheduler;

    localparam int NV = 8;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_tick = 1'b0;
    logic          i_note_valid = 1'b0;
    logic          i_note_on = 1'b0;
    logic [6:0]    i_midi = '0;
    logic          o_note_ready;
    logic [PW-1:0] o_phase;
    logic [6:0]    o_midi;
    logic          o_valid;
    logic [2:0]    o_voice;
    logic          o_last;
    logic          o_overrun;

    voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_tick       (i_tick),
        .i_note_valid (i_note_valid),
        .i_note_on    (i_note_on),
        .i_midi       (i_midi),
        .o_note_ready (o_note_ready),
        .o_phase      (o_phase),
        .o_midi       (o_midi),
        .o_valid      (o_valid),
        .o_voice      (o_voice),
        .o_last       (o_last),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    // Behavioural voice model
    bit            m_act [NV];
    int            m_mid [NV];
    logic [PW-1:0] m_inc [NV];
    logic [PW-1:0] m_ph  [NV];
    int            m_steal;

    // Last sweep as seen on the outputs
    bit            cap_valid [NV];
    int            cap_midi  [NV];
    logic [PW-1:0] cap_phase [NV];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int exp_inc(input int n);
        real f;
        f = 440.0 * $pow(2.0, (n - 69) / 12.0) * 16777216.0 / 48000.0;
        return $rtoi(f + 0.5);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_mid[i] = 0; m_inc[i] = '0; m_ph[i] = '0;
        end
        m_steal = 0;
    endfunction

    function automatic void model_on(input int m);
        int t;
        t = -1;
        for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) t = i;
        if (t < 0) begin
            t = m_steal;
            m_steal = (m_steal + 1) % NV;
        end
        m_act[t] = 1; m_mid[t] = m; m_inc[t] = PW'(exp_inc(m)); m_ph[t] = '0;
    endfunction

    function automatic void model_off(input int m);
        for (int i = 0; i < NV; i++) if (m_act[i] && m_mid[i] == m) m_act[i] = 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; i_tick = 0; i_note_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        chk("rst_phase", o_phase, 0);
        chk("rst_midi", o_midi, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_voice", o_voice, 0);
        chk("rst_last", o_last, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_ready", o_note_ready, 1);
    endtask

    task automatic note(input bit on, input int m);
        @(negedge clk);
        chk("ready_idle", o_note_ready, 1);
        i_note_valid = 1; i_note_on = on; i_midi = 7'(m);
        @(negedge clk);
        i_note_valid = 0;
        if (on) begin
            chk("ready_alloc", o_note_ready, 0);
            model_on(m);
        end else begin
            model_off(m);
        end
    endtask

    // One full sweep, every slot compared against the model.
    task automatic tick_sweep();
        @(negedge clk);
        i_tick = 1; i_note_valid = 0;
        @(negedge clk);
        i_tick = 0;
        chk("ready_in_sweep", o_note_ready, 0);
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            chk("sweep_voice", o_voice, k);
            chk("sweep_valid", o_valid, m_act[k]);
            chk("sweep_last", o_last, (k == NV - 1));
            cap_valid[k] = o_valid; cap_midi[k] = o_midi; cap_phase[k] = o_phase;
            if (m_act[k]) begin
                chk("sweep_midi", o_midi, m_mid[k]);
                chk("sweep_phase", o_phase, m_ph[k]);
                m_ph[k] = m_ph[k] + m_inc[k];
            end
        end
        chk("ready_after", o_note_ready, 1);
        @(negedge clk);
        chk("valid_idle", o_valid, 0);
        chk("last_idle", o_last, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ov, r, m;
        logic [PW-1:0] p0 [3];
        bit found;

        // Pin the increment model to known table values
        chk("inc69", exp_inc(69), 153791);
        chk("inc60", exp_inc(60), 91445);

        rst = 1;
        #12;
        do_reset();

        // Idle sweep: everything inactive
        tick_sweep();

        // Single voice phase progression
        note(1, 69);
        for (int t = 0; t < 3; t++) begin
            tick_sweep();
            p0[t] = cap_phase[0];
        end
        chk("v0_midi", cap_midi[0], 69);
        chk("v0_phase0", p0[0], 0);
        chk("v0_phase1", p0[1], 153791);
        chk("v0_phase2", p0[2], 307582);
        chk("v1_off", cap_valid[1], 0);

        // Freed slot is reused lowest-first
        do_reset();
        note(1, 60); note(1, 62); note(1, 64);
        note(0, 62);
        note(1, 67);
        tick_sweep();
        chk("reuse_v1_midi", cap_midi[1], 67);
        chk("reuse_v1_valid", cap_valid[1], 1);

        // Stealing once all slots are busy
        do_reset();
        for (int n = 60; n <= 68; n++) note(1, n);
        tick_sweep();
        chk("steal_v0_midi", cap_midi[0], 68);
        chk("steal_v0_phase", cap_phase[0], 0);
        chk("steal_v1_midi", cap_midi[1], 61);
        note(1, 69);
        tick_sweep();
        chk("steal2_v1_midi", cap_midi[1], 69);
        chk("steal2_v1_phase", cap_phase[1], 0);
        chk("steal2_v0_midi", cap_midi[0], 68);

        // Event held off by a tick; second tick mid-sweep overruns once
        do_reset();
        @(negedge clk);
        i_tick = 1; i_note_valid = 1; i_note_on = 1; i_midi = 7'd70;
        #1 chk("ready_tick", o_note_ready, 0);
        c = 0; ov = 0;
        do begin
            @(negedge clk);
            c++;
            if (o_overrun) ov++;
            i_tick = (c == 3);
        end while (!o_note_ready && c < 40);
        chk("held_cycles", c, NV + 1);
        @(negedge clk);
        i_note_valid = 0;
        if (o_overrun) ov++;
        model_on(70);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (o_overrun) ov++;
            chk("no_extra_sweep", o_valid, 0);
        end
        chk("overrun_pulses", ov, 1);
        tick_sweep();
        chk("held_v0_midi", cap_midi[0], 70);

        // Reset in the middle of a sweep
        do_reset();
        note(1, 60); note(1, 61);
        tick_sweep();
        @(negedge clk);
        i_tick = 1;
        @(negedge clk);
        i_tick = 0;
        found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            @(negedge clk);
            if (o_voice == 3'd3) found = 1;
        end
        chk("reached_k3", found, 1);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_phase", o_phase, 0);
        chk("mid_rst_midi", o_midi, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_voice", o_voice, 0);
        chk("mid_rst_last", o_last, 0);
        chk("mid_rst_overrun", o_overrun, 0);
        rst = 0;
        model_clear();
        tick_sweep();
        chk("post_rst_v0", cap_valid[0], 0);
        chk("post_rst_v1", cap_valid[1], 0);

        // Randomized mix; high notes force accumulator wrap
        do_reset();
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            m = ($urandom_range(0, 1) == 1) ? $urandom_range(120, 127) : $urandom_range(60, 67);
            if (r < 5)      note(1, m);
            else if (r < 7) note(0, m);
            else            tick_sweep();
        end
        tick_sweep();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
